// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - register offsets and edge encodings shared by the LED and button PIOs
package soc_system_pio_pkg;

    // Word offsets on the Avalon-MM slave
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // EDGE_TYPE parameter encodings
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// rtl/soc_system_pio_debounce.sv - per-bit stable-count debouncer for synchronized inputs
//
// Only present when SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN is defined.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   raw_i    in  WIDTH synchronized (not yet debounced) inputs
//   level_o  out WIDTH accepted levels, reset to 0
`ifdef SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
module soc_system_pio_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] level_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_d;

        // Any sample that agrees with the accepted level restarts the count,
        // so only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips it.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q[i];
            if (raw_i[i] == level_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = ~level_q[i];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q      <= '0;
                level_q[i] <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                level_q[i] <= level_d;
            end
        end
    end

    assign level_o = level_q;

endmodule
`endif

// File: rtl/soc_system_button_pio.sv
// rtl/soc_system_button_pio.sv - Avalon-MM input PIO with sticky edge capture and level IRQ
//
// Optional debounce stage: define SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN.
// Ports:
//   clk         in  system clock
//   reset_n     in  asynchronous active-low reset
//   address     in  2-bit word offset (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect  in  slave select
//   write_n     in  active-low write strobe
//   writedata   in  32-bit write data
//   in_port     in  WIDTH asynchronous external inputs
//   readdata    out 32-bit combinational read data, zero-extended
//   irq         out level interrupt, active high
module soc_system_button_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] rise, fall, det, clr;
    logic             wr_en;

    // Only writedata[WIDTH-1:0] is meaningful; upper bits are ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

`ifdef SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
    soc_system_pio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (sync2_q),
        .level_o (level)
    );
`else
    localparam int UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;
    assign level = sync2_q;
`endif

    // prev resets to 0: a key held high at reset looks like a rising edge
    // (ignored for falling-edge builds), a key held low produces nothing.
    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

    always_comb begin
        det = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  det = rise;
            EDGE_FALLING: det = fall;
            default:      det = rise | fall;
        endcase
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            clr = writedata[WIDTH-1:0];
        end
        // OR-ing det after the clear lets a coincident new edge survive.
        edgecap_d = (edgecap_q & ~clr) | det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            edgecap_q <= '0;
            irqmask_q <= '0;
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            prev_q    <= level;
            edgecap_q <= edgecap_d;
            irqmask_q <= irqmask_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(level);
            ADDR_RSVD:    readdata = '0;
            ADDR_IRQMASK: readdata = 32'(irqmask_q);
            ADDR_EDGECAP: readdata = 32'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_button_pio.sv
// tb/tb_soc_system_button_pio.sv - directed self-checking bench for soc_system_button_pio
module tb_soc_system_button_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    soc_system_button_pio #(
        .WIDTH           (2),
        .EDGE_TYPE       (1),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b11;
        tick(3);
        rd(0, "rst_data", 0);
        rd(2, "rst_irqmask", 0);
        rd(3, "rst_edgecap", 0);
        chk("rst_irq", {31'd0, irq}, 0);

`ifndef SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
        // 1: keys held high through reset release
        reset_n = 1'b1;
        tick(2);
        rd(0, "t1_data", 3);
        tick(3);
        rd(3, "t1_edgecap", 0);
        chk("t1_irq", {31'd0, irq}, 0);

        // 2: falling edge on bit0 with bit0 unmasked
        wr(2, 32'h1);
        rd(2, "t2_irqmask", 1);
        in_port = 2'b10;
        tick(2);
        rd(3, "t2_edgecap_early", 0);
        tick();
        rd(3, "t2_edgecap", 1);
        chk("t2_irq", {31'd0, irq}, 1);
        wr(3, 32'h1);
        rd(3, "t2_edgecap_clr", 0);
        chk("t2_irq_clr", {31'd0, irq}, 0);

        // 3: masked capture on bit1, then unmask
        in_port = 2'b00;
        tick(3);
        rd(3, "t3_edgecap", 2);
        chk("t3_irq_masked", {31'd0, irq}, 0);
        wr(2, 32'h3);
        chk("t3_irq_unmasked", {31'd0, irq}, 1);
        wr(3, 32'h2);
        chk("t3_irq_clr", {31'd0, irq}, 0);

        // 4: clear coincides with a new bit0 edge
        in_port = 2'b11;
        tick(4);
        rd(3, "t4_rise_ignored", 0);
        in_port = 2'b10;
        tick(2);
        wr(3, 32'h1);
        rd(3, "t4_edge_wins", 1);
        wr(3, 32'h1);
        rd(3, "t4_cleared", 0);

        // 5: writes to read-only / reserved and wide IRQMASK write
        wr(0, 32'h0);
        wr(1, 32'hFFFF_FFFF);
        rd(0, "t5_data", 2);
        rd(1, "t5_rsvd", 0);
        wr(2, 32'hFFFF_FFFF);
        rd(2, "t5_irqmask", 3);

        // asynchronous reset in the middle of a pending interrupt
        in_port = 2'b00;
        tick(3);
        rd(3, "rr_edgecap_set", 2);
        chk("rr_irq_set", {31'd0, irq}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rr_irq_drop", {31'd0, irq}, 0);
        rd(3, "rr_edgecap", 0);
        rd(2, "rr_irqmask", 0);
        rd(0, "rr_data", 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(4);
        rd(3, "rr_no_spurious", 0);
`else
        // 6: debounce build, DEBOUNCE_CYCLES = 8
        reset_n = 1'b1;
        tick(2);
        rd(0, "t6_data_pending", 0);
        tick(10);
        rd(0, "t6_data_accepted", 3);
        wr(2, 32'h1);
        in_port = 2'b10;
        tick(5);
        in_port = 2'b11;
        tick(15);
        rd(3, "t6_glitch", 0);
        rd(0, "t6_glitch_data", 3);
        in_port = 2'b10;
        tick(10);
        rd(3, "t6_early", 0);
        tick();
        rd(3, "t6_edgecap", 1);
        chk("t6_irq", {31'd0, irq}, 1);
        in_port = 2'b11;
        tick(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_irq", {31'd0, irq}, 0);
        rd(3, "t6_rst_edgecap", 0);
        rd(2, "t6_rst_irqmask", 0);
        rd(0, "t6_rst_data", 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(2);
        rd(0, "t6_rst_relearn", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
